twofish_subkey_store: RTL and testbench

//  Sequential consumer of the func_h subkey pairs. On start it steps a = 0..19 through one

---
 rtl/twofish_pkg.sv | 73 +++++++
 rtl/func_h.sv | 40 ++++
 rtl/twofish_subkey_store.sv | 136 +++++++++++++
 tb/tb_twofish_subkey_store.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/twofish_pkg.sv
// Shared Twofish key-schedule definitions.
// Holds subkey file geometry, the key-store FSM encoding and the byte-level
// primitives (q0/q1 permutations, GF(2^8) multiply over x^8+x^6+x^5+x^3+1,
// and the MDS matrix) that func_h is built from.
package twofish_pkg;

  localparam int NUM_SUBKEYS = 40;
  localparam int NUM_PAIRS   = 20;
  localparam int NUM_ROUNDS  = 16;
  localparam int WK_BASE_IN  = 0;
  localparam int WK_BASE_OUT = 4;
  localparam int RK_BASE     = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    DONE = 2'd2
  } ks_state_e;

  // Nibble tables t0..t3 for q0 and q1.
  localparam logic [3:0] Q0_T0 [16] = '{4'h8,4'h1,4'h7,4'hD,4'h6,4'hF,4'h3,4'h2,4'h0,4'hB,4'h5,4'h9,4'hE,4'hC,4'hA,4'h4};
  localparam logic [3:0] Q0_T1 [16] = '{4'hE,4'hC,4'hB,4'h8,4'h1,4'h2,4'h3,4'h5,4'hF,4'h4,4'hA,4'h6,4'h7,4'h0,4'h9,4'hD};
  localparam logic [3:0] Q0_T2 [16] = '{4'hB,4'hA,4'h5,4'hE,4'h6,4'hD,4'h9,4'h0,4'hC,4'h8,4'hF,4'h3,4'h2,4'h4,4'h7,4'h1};
  localparam logic [3:0] Q0_T3 [16] = '{4'hD,4'h7,4'hF,4'h4,4'h1,4'h2,4'h6,4'hE,4'h9,4'hB,4'h3,4'h0,4'h8,4'h5,4'hC,4'hA};
  localparam logic [3:0] Q1_T0 [16] = '{4'h2,4'h8,4'hB,4'hD,4'hF,4'h7,4'h6,4'hE,4'h3,4'h1,4'h9,4'h4,4'h0,4'hA,4'hC,4'h5};
  localparam logic [3:0] Q1_T1 [16] = '{4'h1,4'hE,4'h2,4'hB,4'h4,4'hC,4'h3,4'h7,4'h6,4'hD,4'hA,4'h5,4'hF,4'h9,4'h0,4'h8};
  localparam logic [3:0] Q1_T2 [16] = '{4'h4,4'hC,4'h7,4'h5,4'h1,4'h6,4'h9,4'hA,4'h0,4'hE,4'hD,4'h8,4'h2,4'hB,4'h3,4'hF};
  localparam logic [3:0] Q1_T3 [16] = '{4'hB,4'h9,4'h5,4'h1,4'hC,4'h3,4'hD,4'hE,4'h6,4'h4,4'h7,4'hF,4'h2,4'h0,4'h8,4'hA};

  function automatic logic [3:0] ror4(input logic [3:0] v);
    return {v[0], v[3:1]};
  endfunction

  // sel=0 -> q0, sel=1 -> q1. Two mixing rounds of 4-bit table lookups.
  function automatic logic [7:0] q_perm(input logic sel, input logic [7:0] x);
    logic [3:0] a0, b0, a1, b1, a2, b2, a3, b3, a4, b4;
    a0 = x[7:4];
    b0 = x[3:0];
    a1 = a0 ^ b0;
    b1 = a0 ^ ror4(b0) ^ {a0[0], 3'b000};
    a2 = sel ? Q1_T0[a1] : Q0_T0[a1];
    b2 = sel ? Q1_T1[b1] : Q0_T1[b1];
    a3 = a2 ^ b2;
    b3 = a2 ^ ror4(b2) ^ {a2[0], 3'b000};
    a4 = sel ? Q1_T2[a3] : Q0_T2[a3];
    b4 = sel ? Q1_T3[b3] : Q0_T3[b3];
    return {b4, a4};
  endfunction

  // GF(2^8) multiply, reduction polynomial 0x169.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc, p;
    acc = '0;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = {p[6:0], 1'b0} ^ (p[7] ? 8'h69 : 8'h00);
    end
    return acc;
  endfunction

  // MDS multiply; byte 0 of y/z is the least significant byte.
  function automatic logic [31:0] mds(input logic [31:0] y);
    logic [7:0] y0, y1, y2, y3, z0, z1, z2, z3;
    {y3, y2, y1, y0} = y;
    z0 = y0                ^ gf_mul(8'hEF, y1) ^ gf_mul(8'h5B, y2) ^ gf_mul(8'h5B, y3);
    z1 = gf_mul(8'h5B, y0) ^ gf_mul(8'hEF, y1) ^ gf_mul(8'hEF, y2) ^ y3;
    z2 = gf_mul(8'hEF, y0) ^ gf_mul(8'h5B, y1) ^ y2                ^ gf_mul(8'hEF, y3);
    z3 = gf_mul(8'hEF, y0) ^ y1                ^ gf_mul(8'hEF, y2) ^ gf_mul(8'h5B, y3);
    return {z3, z2, z1, z0};
  endfunction

endpackage

// File: rtl/func_h.sv
// func_h: one Twofish key-schedule step for a 128-bit key (k=2).
// Given the key words {M0,M1,M2,M3} and pair index a, produces
//   A = h(2a*rho, {M0,M2}),  B = ROL(h((2a+1)*rho, {M1,M3}), 8)
//   k_even = A + B,          k_odd = ROL(A + 2B, 9)
// Ports: key_i (128), a_i (5) in; k_even_o, k_odd_o (32) out. Purely combinational.
module func_h
  import twofish_pkg::*;
(
  input  logic [127:0] key_i,
  input  logic [4:0]   a_i,
  output logic [31:0]  k_even_o,
  output logic [31:0]  k_odd_o
);

  // Key-dependent S-box stage chain followed by MDS; l0/l1 are the two key words.
  function automatic logic [31:0] h_fn(input logic [7:0] xb, input logic [31:0] l0,
                                       input logic [31:0] l1);
    logic [7:0] y0, y1, y2, y3;
    y0 = q_perm(1'b1, q_perm(1'b0, q_perm(1'b0, xb) ^ l1[7:0])   ^ l0[7:0]);
    y1 = q_perm(1'b0, q_perm(1'b0, q_perm(1'b1, xb) ^ l1[15:8])  ^ l0[15:8]);
    y2 = q_perm(1'b1, q_perm(1'b1, q_perm(1'b0, xb) ^ l1[23:16]) ^ l0[23:16]);
    y3 = q_perm(1'b0, q_perm(1'b1, q_perm(1'b1, xb) ^ l1[31:24]) ^ l0[31:24]);
    return mds({y3, y2, y1, y0});
  endfunction

  logic [31:0] m0, m1, m2, m3;
  logic [31:0] h_a, h_b, b_rot, a_2b;

  assign {m0, m1, m2, m3} = key_i;

  // All four input bytes equal, so h only needs the single byte value.
  assign h_a   = h_fn({2'b00, a_i, 1'b0}, m0, m2);
  assign h_b   = h_fn({2'b00, a_i, 1'b1}, m1, m3);
  assign b_rot = {h_b[23:0], h_b[31:24]};
  assign a_2b  = h_a + {b_rot[30:0], 1'b0};

  assign k_even_o = h_a + b_rot;
  assign k_odd_o  = {a_2b[22:0], a_2b[31:23]};

endmodule

// File: rtl/twofish_subkey_store.sv
// twofish_subkey_store: sequential Twofish subkey generator and key server.
// On start, captures the user key and walks a = 0..19 through one func_h,
// writing K[2a]/K[2a+1] each cycle into a 40x32 register file. Once ready,
// serves round key pairs (registered, 1-cycle latency) and whitening keys
// (combinational) in encrypt or reversed decrypt order.
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   start_i, key_i[127:0]    generation request and key {M0,M1,M2,M3}
//   busy_o, ready_o          generation running / all subkeys valid
//   rd_en_i, rd_dec_i,
//   rd_round_i[3:0]          round-key read request, order, logical round
//   rd_valid_o,
//   rd_k0_o, rd_k1_o[31:0]   registered round key pair
//   wk_in_o, wk_out_o[127:0] whitening keys, qualify with ready_o
module twofish_subkey_store
  import twofish_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [127:0] key_i,
  output logic         busy_o,
  output logic         ready_o,
  input  logic         rd_en_i,
  input  logic         rd_dec_i,
  input  logic [3:0]   rd_round_i,
  output logic         rd_valid_o,
  output logic [31:0]  rd_k0_o,
  output logic [31:0]  rd_k1_o,
  output logic [127:0] wk_in_o,
  output logic [127:0] wk_out_o
);

  localparam logic [4:0] LAST_PAIR = 5'(NUM_PAIRS - 1);

  ks_state_e                         state_q;
  logic [4:0]                        a_q;
  logic [127:0]                      key_q;
  logic                              busy_q, ready_q;
  logic [NUM_SUBKEYS-1:0][31:0]      file_q;
  logic                              rd_valid_q;
  logic [31:0]                       rd_k0_q, rd_k1_q;

  logic [31:0] k_even, k_odd;

  func_h u_func_h (
    .key_i    (key_q),
    .a_i      (a_q),
    .k_even_o (k_even),
    .k_odd_o  (k_odd)
  );

  // Control FSM. start is only honoured outside GEN, so a running
  // generation can never be disturbed mid-way.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      key_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            key_q   <= key_i;
            a_q     <= '0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            state_q <= GEN;
          end
        end
        GEN: begin
          // a stays at the last pair so the write index can never pass K39.
          if (a_q == LAST_PAIR) begin
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= DONE;
          end else begin
            a_q <= a_q + 5'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Subkey file: one even/odd pair written per GEN cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      file_q <= '0;
    end else if (state_q == GEN) begin
      file_q[{a_q, 1'b0}] <= k_even;
      file_q[{a_q, 1'b1}] <= k_odd;
    end
  end

  // Decrypt walks the rounds backwards: r' = 15 - r.
  logic [3:0] rd_r;
  logic [5:0] rd_idx0, rd_idx1;

  assign rd_r    = rd_dec_i ? (4'(NUM_ROUNDS - 1) - rd_round_i) : rd_round_i;
  assign rd_idx0 = 6'(RK_BASE) + {1'b0, rd_r, 1'b0};
  assign rd_idx1 = rd_idx0 | 6'd1;

  // Data registers only load on an accepted read; otherwise they hold.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid_q <= 1'b0;
      rd_k0_q    <= '0;
      rd_k1_q    <= '0;
    end else begin
      rd_valid_q <= rd_en_i & ready_q;
      if (rd_en_i && ready_q) begin
        rd_k0_q <= file_q[rd_idx0];
        rd_k1_q <= file_q[rd_idx1];
      end
    end
  end

  logic [127:0] wk_lo, wk_hi;

  assign wk_lo = {file_q[WK_BASE_IN],  file_q[WK_BASE_IN+1],
                  file_q[WK_BASE_IN+2], file_q[WK_BASE_IN+3]};
  assign wk_hi = {file_q[WK_BASE_OUT],  file_q[WK_BASE_OUT+1],
                  file_q[WK_BASE_OUT+2], file_q[WK_BASE_OUT+3]};

  assign wk_in_o    = rd_dec_i ? wk_hi : wk_lo;
  assign wk_out_o   = rd_dec_i ? wk_lo : wk_hi;
  assign busy_o     = busy_q;
  assign ready_o    = ready_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_k0_o    = rd_k0_q;
  assign rd_k1_o    = rd_k1_q;

endmodule

// File: tb/tb_twofish_subkey_store.sv
module tb_twofish_subkey_store;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key = '0;
  logic         rd_en = 1'b0;
  logic         rd_dec = 1'b0;
  logic [3:0]   rd_round = '0;
  logic         busy, ready, rd_valid;
  logic [31:0]  rd_k0, rd_k1;
  logic [127:0] wk_in, wk_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_k [40];
  logic [63:0] sb_q [$];
  logic [63:0] last_rd = '0;
  logic [7:0]  q0t [256];
  logic [7:0]  q1t [256];

  // Nibble tables written left-to-right: entry i is nibble i counted from the MSB.
  localparam logic [63:0] QT [8] = '{
    64'h817D6F320B59ECA4, 64'hECB81235F4A6709D, 64'hBA5E6D90C8F32471, 64'hD7F4126E9B3085CA,
    64'h28BDF76E31940AC5, 64'h1E2B4C376DA5F908, 64'h4C75169A0ED82B3F, 64'hB951C3DE647F208A};
  localparam int MDS_M [16] = '{'h01,'hEF,'h5B,'h5B, 'h5B,'hEF,'hEF,'h01,
                                'hEF,'h5B,'h01,'hEF, 'hEF,'h01,'hEF,'h5B};
  // Per byte lane, q choice for the 1st/2nd/3rd lookup in bits 0/1/2.
  localparam logic [2:0] QS [4] = '{3'b100, 3'b001, 3'b110, 3'b011};

  twofish_subkey_store dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .key_i(key),
    .busy_o(busy), .ready_o(ready),
    .rd_en_i(rd_en), .rd_dec_i(rd_dec), .rd_round_i(rd_round),
    .rd_valid_o(rd_valid), .rd_k0_o(rd_k0), .rd_k1_o(rd_k1),
    .wk_in_o(wk_in), .wk_out_o(wk_out));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] q_calc(input int sel, input logic [7:0] x);
    logic [3:0] a, b, ta, tb;
    logic [63:0] t0, t1;
    a = x[7:4];
    b = x[3:0];
    for (int s = 0; s < 2; s++) begin
      t0 = QT[sel*4 + 2*s];
      t1 = QT[sel*4 + 2*s + 1];
      ta = a ^ b;
      tb = a ^ {b[0], b[3:1]} ^ {a[0], 3'b000};
      a = t0[(15 - ta)*4 +: 4];
      b = t1[(15 - tb)*4 +: 4];
    end
    return {b, a};
  endfunction

  // Carry-less product, then reduce modulo 0x169.
  function automatic int gmul(input int a, input int b);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++) if (((b >> i) & 1) != 0) p = p ^ (a << i);
    for (int i = 14; i >= 8; i--) if (((p >> i) & 1) != 0) p = p ^ ('h169 << (i - 8));
    return p & 255;
  endfunction

  function automatic logic [31:0] h_model(input logic [7:0] xb, input logic [31:0] l0,
                                          input logic [31:0] l1);
    logic [7:0]  y [4];
    logic [7:0]  v;
    logic [2:0]  qs;
    logic [31:0] z;
    int acc;
    for (int j = 0; j < 4; j++) begin
      qs = QS[j];
      v = qs[0] ? q1t[xb] : q0t[xb];
      v = v ^ l1[8*j +: 8];
      v = qs[1] ? q1t[v] : q0t[v];
      v = v ^ l0[8*j +: 8];
      y[j] = qs[2] ? q1t[v] : q0t[v];
    end
    z = '0;
    for (int i = 0; i < 4; i++) begin
      acc = 0;
      for (int j = 0; j < 4; j++) acc = acc ^ gmul(MDS_M[i*4 + j], int'(y[j]));
      z[8*i +: 8] = 8'(acc);
    end
    return z;
  endfunction

  function automatic void compute_keys(input logic [127:0] k);
    logic [31:0] m0, m1, m2, m3, a, b;
    {m0, m1, m2, m3} = k;
    for (int i = 0; i < 20; i++) begin
      a = h_model(8'(2*i), m0, m2);
      b = h_model(8'(2*i + 1), m1, m3);
      b = (b << 8) | (b >> 24);
      exp_k[2*i] = a + b;
      a = a + (b << 1);
      exp_k[2*i + 1] = (a << 9) | (a >> 23);
    end
  endfunction

  // ---------------- scenario tasks (all enter/leave in the clock-low phase) ----------------
  // Pulse start, then track busy/ready edge by edge. Optionally re-pulse start
  // mid-generation with another key and/or hold rd_en high while busy.
  task automatic gen_and_wait(input logic [127:0] k, input bit inject, input logic [127:0] k2,
                              input bit rd_busy, input string tag);
    key = k; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      n_checks++;
      if ({busy, ready} !== 2'b10) begin
        n_fail++;
        $display("FAIL %s busy/ready gen cycle %0d: got %b%b want 10", tag, c, busy, ready);
      end
      if (rd_busy && c > 0) begin
        n_checks++;
        if ({rd_valid, rd_k0, rd_k1} !== {1'b0, last_rd}) begin
          n_fail++;
          $display("FAIL %s rd while busy cycle %0d: got v=%b %h%h want v=0 %h", tag, c,
                   rd_valid, rd_k0, rd_k1, last_rd);
        end
      end
      if (inject && c == 5) begin key = k2; start = 1'b1; end
      if (inject && c == 6) start = 1'b0;
      if (rd_busy) begin rd_en = 1'b1; rd_round = 4'(c); end
      @(negedge clk);
    end
    rd_en = 1'b0;
    n_checks++;
    if ({busy, ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL %s ready after 20 cycles: got busy=%b ready=%b want 0 1", tag, busy, ready);
    end
  endtask

  // Back-to-back reads of all 16 rounds in a scrambled order, via the scoreboard.
  task automatic read_all(input bit dec, input string tag);
    logic [63:0] exp;
    int r, rp;
    for (int i = 0; i <= 16; i++) begin
      if (sb_q.size() > 0) begin
        exp = sb_q.pop_front();
        n_checks++;
        if (rd_valid !== 1'b1 || {rd_k0, rd_k1} !== exp) begin
          n_fail++;
          $display("FAIL %s read dec=%0d: got v=%b %h_%h want v=1 %h_%h", tag, dec,
                   rd_valid, rd_k0, rd_k1, exp[63:32], exp[31:0]);
        end
        last_rd = exp;
      end
      if (i < 16) begin
        r  = (i * 7) & 15;
        rp = dec ? 15 - r : r;
        sb_q.push_back({exp_k[2*rp + 8], exp_k[2*rp + 9]});
        rd_en = 1'b1; rd_dec = dec; rd_round = 4'(r);
      end else begin
        rd_en = 1'b0; rd_dec = 1'b0;
      end
      @(negedge clk);
    end
    n_checks++;
    if ({rd_valid, rd_k0, rd_k1} !== {1'b0, last_rd}) begin
      n_fail++;
      $display("FAIL %s read hold: got v=%b %h%h want v=0 %h", tag, rd_valid, rd_k0, rd_k1, last_rd);
    end
  endtask

  task automatic check_wk(input string tag);
    logic [127:0] lo, hi;
    lo = {exp_k[0], exp_k[1], exp_k[2], exp_k[3]};
    hi = {exp_k[4], exp_k[5], exp_k[6], exp_k[7]};
    rd_dec = 1'b0; #1;
    n_checks++;
    if (wk_in !== lo || wk_out !== hi) begin
      n_fail++;
      $display("FAIL %s wk enc: got in=%h out=%h want in=%h out=%h", tag, wk_in, wk_out, lo, hi);
    end
    rd_dec = 1'b1; #1;
    n_checks++;
    if (wk_in !== hi || wk_out !== lo) begin
      n_fail++;
      $display("FAIL %s wk dec: got in=%h out=%h want in=%h out=%h", tag, wk_in, wk_out, hi, lo);
    end
    rd_dec = 1'b0; #1;
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if ({busy, ready, rd_valid, rd_k0, rd_k1} !== '0 || wk_in !== '0 || wk_out !== '0) begin
      n_fail++;
      $display("FAIL reset state: got busy=%b ready=%b v=%b k0=%h k1=%h wk_in=%h wk_out=%h want all 0",
               busy, ready, rd_valid, rd_k0, rd_k1, wk_in, wk_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_gen_zero();
    compute_keys('0);
    gen_and_wait('0, 1'b0, '0, 1'b0, "zero_key");
    n_checks++;
    if (wk_in[127:64] !== 64'h52C54DDE11F0626D) begin
      n_fail++;
      $display("FAIL zero_key K0K1: got %h want 52c54dde11f0626d", wk_in[127:64]);
    end
    read_all(1'b0, "zero_key");
    read_all(1'b1, "zero_key");
  endtask

  task automatic test_whitening();
    check_wk("whiten");
  endtask

  task automatic test_ignored_start();
    compute_keys(128'h00112233_44556677_8899AABB_CCDDEEFF);
    gen_and_wait(128'h00112233_44556677_8899AABB_CCDDEEFF, 1'b1,
                 {$urandom, $urandom, $urandom, $urandom}, 1'b0, "ignored_start");
    read_all(1'b0, "ignored_start");
    check_wk("ignored_start");
  endtask

  task automatic test_reset_mid();
    compute_keys(128'hDEADBEEF_0BADF00D_C0FFEE00_12345678);
    key = 128'hDEADBEEF_0BADF00D_C0FFEE00_12345678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid busy before reset: got %b want 1", busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, ready, rd_valid, rd_k0, rd_k1} !== '0 || wk_in !== '0 || wk_out !== '0) begin
      n_fail++;
      $display("FAIL reset_mid async clear: got busy=%b ready=%b v=%b k0=%h k1=%h wk_in=%h want all 0",
               busy, ready, rd_valid, rd_k0, rd_k1, wk_in);
    end
    last_rd = '0;
    @(negedge clk);
    rst_n = 1'b1;
    gen_and_wait(128'hDEADBEEF_0BADF00D_C0FFEE00_12345678, 1'b0, '0, 1'b0, "reset_mid");
    read_all(1'b1, "reset_mid");
    check_wk("reset_mid");
  endtask

  task automatic test_busy_read_restart();
    compute_keys(128'h01234567_89ABCDEF_FEDCBA98_76543210);
    gen_and_wait(128'h01234567_89ABCDEF_FEDCBA98_76543210, 1'b0, '0, 1'b1, "restart");
    read_all(1'b0, "restart");
    read_all(1'b1, "restart");
    check_wk("restart");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      q0t[i] = q_calc(0, 8'(i));
      q1t[i] = q_calc(1, 8'(i));
    end
    test_reset();
    test_gen_zero();
    test_whitening();
    test_ignored_start();
    test_reset_mid();
    test_busy_read_restart();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
